// File: rtl/oled_gfx_pkg.sv
// Shared OLED graphics definitions: panel geometry, pixel index width,
// RGB565 colour constants, the level type and a counter-width helper.
package oled_gfx_pkg;

    localparam int unsigned OLED_W = 96;
    localparam int unsigned OLED_H = 64;
    localparam int unsigned IDX_W  = 13;

    typedef logic [15:0] rgb565_t;

    localparam rgb565_t RGB_BLACK  = 16'h0000;
    localparam rgb565_t RGB_WHITE  = 16'hFFFF;
    localparam rgb565_t RGB_RED    = 16'hF800;
    localparam rgb565_t RGB_GREEN  = 16'h07E0;
    localparam rgb565_t RGB_YELLOW = 16'hFFE0;
    localparam rgb565_t RGB_BLUE   = 16'h001F;

    // Level width for the default range 0..16
    localparam int unsigned LEVEL_W = 5;
    typedef logic [LEVEL_W-1:0] level_t;

    // Width of a counter that must hold values 0..n-1 (never zero bits)
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fft_bar_graph_peak_if.sv
// Pixel/level bus between the FFT quantiser + OLED driver and the bar renderer.
//   level_in   : packed per-bar binary levels, bar b at [b*LVL_W +: LVL_W]
//   index      : OLED pixel index, row-major
//   freeze     : hold all bar/peak state
//   peak_en    : draw peak markers
//   frame_tick : one-cycle pulse at each frame start
//   data       : RGB565 colour for the previous cycle's index
interface fft_bar_graph_peak_if #(
    parameter int unsigned NUM_BARS = 4,
    parameter int unsigned LVL_W    = 5
) ();
    import oled_gfx_pkg::*;

    logic [NUM_BARS*LVL_W-1:0] level_in;
    logic [IDX_W-1:0]          index;
    logic                      freeze;
    logic                      peak_en;
    logic                      frame_tick;
    rgb565_t                   data;

    modport master (
        output level_in, index, freeze, peak_en,
        input  frame_tick, data
    );

    modport slave (
        input  level_in, index, freeze, peak_en,
        output frame_tick, data
    );

endinterface

// File: rtl/bar_level_tracker.sv
// Per-bar display level with fall-off smoothing and peak-hold tracking.
//   clk, reset : clock, async active-high reset
//   i_tick     : frame start pulse
//   i_freeze   : hold all state
//   i_c        : clamped input level for this bar
//   o_disp     : smoothed bar level
//   o_peak     : peak-hold level, never below o_disp
module bar_level_tracker
    import oled_gfx_pkg::*;
#(
    parameter int unsigned LW               = 5,
    parameter int unsigned DECAY_FRAMES     = 4,
    parameter int unsigned PEAK_HOLD_FRAMES = 30
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_tick,
    input  logic          i_freeze,
    input  logic [LW-1:0] i_c,
    output logic [LW-1:0] o_disp,
    output logic [LW-1:0] o_peak
);

    localparam int unsigned DW = cnt_w(DECAY_FRAMES);
    localparam int unsigned HW = cnt_w(PEAK_HOLD_FRAMES + 1);

    logic [LW-1:0] r_disp, r_peak;
    logic [DW-1:0] r_dcnt, r_pcnt;
    logic [HW-1:0] r_hold;

    logic [LW-1:0] w_disp_n, w_peak_n;
    logic [DW-1:0] w_dcnt_n, w_pcnt_n;
    logic [HW-1:0] w_hold_n;

    // Next-state: rise instantly, fall one level every DECAY_FRAMES ticks
    always_comb begin
        w_disp_n = r_disp;
        w_dcnt_n = r_dcnt;
        w_peak_n = r_peak;
        w_pcnt_n = r_pcnt;
        w_hold_n = r_hold;

        if (i_tick && !i_freeze) begin
            if (i_c >= r_disp) begin
                w_disp_n = i_c;
                w_dcnt_n = '0;
            end else if (r_dcnt == DW'(DECAY_FRAMES - 1)) begin
                if (r_disp != '0) begin
                    w_disp_n = r_disp - LW'(1);
                end
                w_dcnt_n = '0;
            end else begin
                w_dcnt_n = r_dcnt + DW'(1);
            end

            if (i_c >= r_peak) begin
                w_peak_n = i_c;
                w_hold_n = HW'(PEAK_HOLD_FRAMES);
                w_pcnt_n = '0;
            end else if (r_hold != '0) begin
                w_hold_n = r_hold - HW'(1);
            end else if (r_pcnt == DW'(DECAY_FRAMES - 1)) begin
                if (r_peak != '0) begin
                    w_peak_n = r_peak - LW'(1);
                end
                w_pcnt_n = '0;
            end else begin
                w_pcnt_n = r_pcnt + DW'(1);
            end

            // Marker must never sit inside the bar
            if (w_peak_n < w_disp_n) begin
                w_peak_n = w_disp_n;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_disp <= '0;
            r_dcnt <= '0;
            r_peak <= '0;
            r_pcnt <= '0;
            r_hold <= '0;
        end else begin
            r_disp <= w_disp_n;
            r_dcnt <= w_dcnt_n;
            r_peak <= w_peak_n;
            r_pcnt <= w_pcnt_n;
            r_hold <= w_hold_n;
        end
    end

    assign o_disp = r_disp;
    assign o_peak = r_peak;

endmodule

// File: rtl/fft_bar_graph_peak.sv
// N-bar spectrum renderer with fall-off smoothing and peak-hold markers for
// the 96x64 RGB565 OLED. Detects frame start from the driver's pixel index,
// updates per-bar levels once per frame and returns a registered pixel colour.
//   clk, reset : clock, async active-high reset
//   io_bus     : slave side of fft_bar_graph_peak_if (levels, index, freeze,
//                peak_en in; frame_tick, data out)
module fft_bar_graph_peak
    import oled_gfx_pkg::*;
#(
    parameter int unsigned NUM_BARS         = 4,
    parameter int unsigned LVL_W            = 5,
    parameter int unsigned MAX_LEVEL        = 16,
    parameter int unsigned DISP_W           = OLED_W,
    parameter int unsigned DISP_H           = OLED_H,
    parameter int unsigned BAR_X0           = 16,
    parameter int unsigned BAR_W            = 16,
    parameter int unsigned BAR_GAP          = 0,
    parameter int unsigned ROWS_PER_LVL     = 4,
    parameter int unsigned DECAY_FRAMES     = 4,
    parameter int unsigned PEAK_HOLD_FRAMES = 30,
    parameter int unsigned COLOR_MODE       = 0,
    parameter rgb565_t     BAR_COLOR        = RGB_BLUE,
    parameter rgb565_t     PEAK_COLOR       = RGB_WHITE
) (
    input  logic                 clk,
    input  logic                 reset,
    fft_bar_graph_peak_if.slave  io_bus
);

    localparam int unsigned LW   = $clog2(MAX_LEVEL + 1);
    localparam int unsigned AW   = 16;
    localparam int unsigned NPIX = DISP_W * DISP_H;

    logic [IDX_W-1:0] r_prev_index;
    logic             r_frame_tick;
    rgb565_t          r_data;

    logic             w_tick;
    logic [LW-1:0]    w_c    [NUM_BARS];
    logic [LW-1:0]    w_disp [NUM_BARS];
    logic [LW-1:0]    w_peak [NUM_BARS];

    // Frame start: index wraps to 0 from a nonzero value
    assign w_tick = (io_bus.index == '0) && (r_prev_index != '0);

    // Clamp each input level and track it
    for (genvar b = 0; b < NUM_BARS; b++) begin : g_bar
        logic [LVL_W-1:0] w_raw;

        assign w_raw  = io_bus.level_in[b*LVL_W +: LVL_W];
        assign w_c[b] = (AW'(w_raw) > AW'(MAX_LEVEL)) ? LW'(MAX_LEVEL) : LW'(w_raw);

        bar_level_tracker #(
            .LW               (LW),
            .DECAY_FRAMES     (DECAY_FRAMES),
            .PEAK_HOLD_FRAMES (PEAK_HOLD_FRAMES)
        ) u_tracker (
            .clk      (clk),
            .reset    (reset),
            .i_tick   (w_tick),
            .i_freeze (io_bus.freeze),
            .i_c      (w_c[b]),
            .o_disp   (w_disp[b]),
            .o_peak   (w_peak[b])
        );
    end

    logic [AW-1:0] w_col, w_row, w_off, w_bar, w_slot;
    logic          w_in_frame, w_bar_ok;
    logic [LW-1:0] w_sel_disp, w_sel_peak;

    // Pixel index -> bar slot, and select that bar's levels
    always_comb begin
        w_in_frame = 32'(io_bus.index) < NPIX;
        w_col      = AW'(32'(io_bus.index) % DISP_W);
        w_row      = AW'(32'(io_bus.index) / DISP_W);
        w_off      = w_col - AW'(BAR_X0);
        w_bar      = w_off / AW'(BAR_W);
        w_slot     = w_off % AW'(BAR_W);
        w_bar_ok   = w_in_frame
                     && (w_col >= AW'(BAR_X0))
                     && (w_bar < AW'(NUM_BARS))
                     && (w_slot < AW'(BAR_W - BAR_GAP));
        w_sel_disp = '0;
        w_sel_peak = '0;
        for (int unsigned b = 0; b < NUM_BARS; b++) begin
            if (w_bar == AW'(b)) begin
                w_sel_disp = w_disp[b];
                w_sel_peak = w_peak[b];
            end
        end
    end

    logic    w_lit, w_mark;
    rgb565_t w_pix;

    // Lit/marker tests written as row + h >= DISP_H so tall levels cannot wrap
    always_comb begin
        w_lit  = (w_sel_disp != '0)
                 && ((w_row + AW'(w_sel_disp) * AW'(ROWS_PER_LVL)) >= AW'(DISP_H));
        w_mark = io_bus.peak_en
                 && (w_sel_peak > w_sel_disp)
                 && ((w_row + AW'(w_sel_peak) * AW'(ROWS_PER_LVL)) == AW'(DISP_H));
        w_pix  = RGB_BLACK;
        if (w_bar_ok) begin
            if (w_mark) begin
                w_pix = PEAK_COLOR;
            end else if (w_lit) begin
                if (COLOR_MODE == 0) begin
                    w_pix = BAR_COLOR;
                end else if (w_row >= AW'(2 * DISP_H / 3)) begin
                    w_pix = RGB_GREEN;
                end else if (w_row >= AW'(DISP_H / 3)) begin
                    w_pix = RGB_YELLOW;
                end else begin
                    w_pix = RGB_RED;
                end
            end
        end
    end

    // Output and frame-detect registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_index <= '0;
            r_frame_tick <= 1'b0;
            r_data       <= RGB_BLACK;
        end else begin
            r_prev_index <= io_bus.index;
            r_frame_tick <= w_tick;
            r_data       <= w_pix;
        end
    end

    assign io_bus.frame_tick = r_frame_tick;
    assign io_bus.data       = r_data;

endmodule

// File: tb/tb_fft_bar_graph_peak.sv
module tb_fft_bar_graph_peak;
    import oled_gfx_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_bar_graph_peak_if #(.NUM_BARS(4), .LVL_W(5)) ifa ();
    fft_bar_graph_peak_if #(.NUM_BARS(5), .LVL_W(5)) ifb ();

    fft_bar_graph_peak u_dut_a (
        .clk    (clk),
        .reset  (rst),
        .io_bus (ifa)
    );

    fft_bar_graph_peak #(
        .NUM_BARS   (5),
        .BAR_W      (12),
        .BAR_GAP    (2),
        .COLOR_MODE (1)
    ) u_dut_b (
        .clk    (clk),
        .reset  (rst),
        .io_bus (ifb)
    );

    typedef struct {
        logic [15:0] data;
        logic        tick;
        int          idx;
    } exp_t;

    exp_t  qa[$];
    exp_t  qb[$];
    int    n_cmp = 0;
    int    n_err = 0;
    string tname;

    // Reference model of DUT A (defaults: 4 bars, 96x64, X0 16, W 16, 4 rows/level)
    int m_disp[4], m_peak[4], m_dcnt[4], m_pcnt[4], m_hold[4];
    int m_prev_a = 0;
    int m_prev_b = 0;

    function automatic void model_clear();
        for (int b = 0; b < 4; b++) begin
            m_disp[b] = 0; m_peak[b] = 0; m_dcnt[b] = 0; m_pcnt[b] = 0; m_hold[b] = 0;
        end
        m_prev_a = 0;
        m_prev_b = 0;
    endfunction

    function automatic void model_tick_a();
        for (int b = 0; b < 4; b++) begin
            int c;
            c = int'(ifa.level_in[b*5 +: 5]);
            if (c > 16) c = 16;
            if (c >= m_disp[b]) begin
                m_disp[b] = c; m_dcnt[b] = 0;
            end else if (m_dcnt[b] == 3) begin
                m_disp[b] = m_disp[b] - 1; m_dcnt[b] = 0;
            end else begin
                m_dcnt[b] = m_dcnt[b] + 1;
            end
            if (c >= m_peak[b]) begin
                m_peak[b] = c; m_hold[b] = 30; m_pcnt[b] = 0;
            end else if (m_hold[b] > 0) begin
                m_hold[b] = m_hold[b] - 1;
            end else if (m_pcnt[b] == 3) begin
                m_peak[b] = m_peak[b] - 1; m_pcnt[b] = 0;
            end else begin
                m_pcnt[b] = m_pcnt[b] + 1;
            end
            if (m_peak[b] < m_disp[b]) m_peak[b] = m_disp[b];
        end
    endfunction

    function automatic logic [15:0] mpix_a(input int idx);
        int col, row, b;
        if (idx >= 96 * 64) return 16'h0000;
        col = idx % 96;
        row = idx / 96;
        if (col < 16) return 16'h0000;
        b = (col - 16) / 16;
        if (b >= 4) return 16'h0000;
        if (ifa.peak_en && m_peak[b] > m_disp[b] && row == 64 - m_peak[b] * 4) return 16'hFFFF;
        if (m_disp[b] > 0 && row >= 64 - m_disp[b] * 4) return 16'h001F;
        return 16'h0000;
    endfunction

    function automatic int pix(input int col, input int row);
        return row * 96 + col;
    endfunction

    // Drive one index into DUT A, queue its expected output, advance one clock
    task automatic stepa(input int idx, input logic [15:0] exp_data);
        exp_t e;
        ifa.index = 13'(idx);
        e.data = exp_data;
        e.tick = (idx == 0) && (m_prev_a != 0);
        e.idx  = idx;
        qa.push_back(e);
        @(posedge clk);
        if (e.tick && !ifa.freeze) model_tick_a();
        m_prev_a = idx;
        @(negedge clk);
    endtask

    task automatic stepb(input int idx, input logic [15:0] exp_data);
        exp_t e;
        ifb.index = 13'(idx);
        e.data = exp_data;
        e.tick = (idx == 0) && (m_prev_b != 0);
        e.idx  = idx;
        qb.push_back(e);
        @(posedge clk);
        m_prev_b = idx;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        qa.delete();
        qb.delete();
    endtask

    task automatic test_reset();
        exp_t e;
        int   fill[4] = '{1, 0, pix(16, 63), pix(32, 63)};
        int   post[7] = '{0, 0, pix(16, 63), 1, 0, 0, 0};
        int   nticks;

        tname = "reset_init";
        n_cmp++;
        if (ifa.data !== 16'h0000 || ifa.frame_tick !== 1'b0) begin
            n_err++;
            $display("FAIL %s: data=%h tick=%b, want data=0000 tick=0", tname, ifa.data, ifa.frame_tick);
        end
        rst = 1'b0;

        tname = "reset_fill";
        ifa.level_in = {5'd0, 5'd0, 5'd10, 5'd16};
        foreach (fill[i]) begin
            stepa(fill[i], mpix_a(fill[i]));
            e = qa.pop_front();
            n_cmp++;
            if (ifa.data !== e.data || ifa.frame_tick !== e.tick) begin
                n_err++;
                $display("FAIL %s idx=%0d: data=%h tick=%b, want data=%h tick=%b",
                         tname, e.idx, ifa.data, ifa.frame_tick, e.data, e.tick);
            end
        end

        // Asynchronous reset in the middle of the low phase
        tname = "reset_async";
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (ifa.data !== 16'h0000 || ifa.frame_tick !== 1'b0) begin
            n_err++;
            $display("FAIL %s: data=%h tick=%b, want data=0000 tick=0", tname, ifa.data, ifa.frame_tick);
        end
        model_clear();
        @(negedge clk);
        rst = 1'b0;

        tname = "reset_post";
        nticks = 0;
        foreach (post[i]) begin
            stepa(post[i], (post[i] == pix(16, 63)) ? 16'h0000 : mpix_a(post[i]));
            e = qa.pop_front();
            n_cmp++;
            if (ifa.frame_tick === 1'b1) nticks++;
            if (ifa.data !== e.data || ifa.frame_tick !== e.tick) begin
                n_err++;
                $display("FAIL %s idx=%0d: data=%h tick=%b, want data=%h tick=%b",
                         tname, e.idx, ifa.data, ifa.frame_tick, e.data, e.tick);
            end
        end
        tname = "reset_tick_count";
        n_cmp++;
        if (nticks != 1) begin
            n_err++;
            $display("FAIL %s: ticks=%0d, want 1", tname, nticks);
        end
    endtask

    task automatic test_full_bar();
        exp_t e;
        int   idx;
        logic [15:0] x;
        do_reset();
        tname = "full_bar";
        ifa.peak_en  = 1'b1;
        ifa.level_in = {5'd0, 5'd0, 5'd0, 5'd16};
        for (int k = 0; k < 1024 + 6; k++) begin
            if (k == 0)         begin idx = 1;            x = 16'h0000; end
            else if (k == 1)    begin idx = 0;            x = 16'h0000; end
            else if (k == 1026) begin idx = pix(32, 63);  x = 16'h0000; end
            else if (k == 1027) begin idx = pix(15, 63);  x = 16'h0000; end
            else if (k == 1028) begin idx = 6144;         x = 16'h0000; end
            else if (k == 1029) begin idx = 8191;         x = 16'h0000; end
            else begin
                idx = pix(16 + (k - 2) % 16, (k - 2) / 16);
                x   = 16'h001F;
            end
            stepa(idx, x);
            e = qa.pop_front();
            n_cmp++;
            if (ifa.data !== e.data || ifa.frame_tick !== e.tick) begin
                n_err++;
                $display("FAIL %s idx=%0d: data=%h tick=%b, want data=%h tick=%b",
                         tname, e.idx, ifa.data, ifa.frame_tick, e.data, e.tick);
            end
        end
    endtask

    task automatic test_decay();
        exp_t e;
        int   seq[7] = '{1, 0, pix(20, 32), pix(20, 35), pix(20, 36), pix(20, 40), pix(20, 63)};
        logic [15:0] cx[5];
        bit   use_c;
        do_reset();
        tname = "decay";
        ifa.peak_en  = 1'b1;
        ifa.level_in = {15'd0, 5'd8};
        for (int k = 0; k <= 40; k++) begin
            if (k == 1) ifa.level_in = '0;
            use_c = 1'b1;
            case (k)
                0:  cx = '{16'h001F, 16'h001F, 16'h001F, 16'h001F, 16'h001F};
                4:  cx = '{16'hFFFF, 16'h0000, 16'h001F, 16'h001F, 16'h001F};
                31: cx = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h001F};
                32: cx = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
                34: cx = '{16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
                40: cx = '{16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000};
                default: use_c = 1'b0;
            endcase
            foreach (seq[i]) begin
                stepa(seq[i], (use_c && i >= 2) ? cx[i-2] : mpix_a(seq[i]));
                e = qa.pop_front();
                n_cmp++;
                if (ifa.data !== e.data || ifa.frame_tick !== e.tick) begin
                    n_err++;
                    $display("FAIL %s k=%0d idx=%0d: data=%h tick=%b, want data=%h tick=%b",
                             tname, k, e.idx, ifa.data, ifa.frame_tick, e.data, e.tick);
                end
            end
        end
    endtask

    task automatic test_clamp();
        exp_t e;
        int   pre[6]  = '{1, 0, pix(48, 0), pix(32, 51), pix(32, 52), pix(16, 0)};
        logic [15:0] prx[6] = '{16'h0000, 16'h0000, 16'h001F, 16'h0000, 16'h001F, 16'h001F};
        int   post[4] = '{pix(16, 0), pix(16, 7), pix(16, 8), pix(48, 0)};
        logic [15:0] pox[4] = '{16'h0000, 16'h0000, 16'h001F, 16'h0000};
        int   npk;
        do_reset();
        tname = "clamp";
        ifa.peak_en  = 1'b0;
        ifa.level_in = {5'd0, 5'd20, 5'd3, 5'd31};
        foreach (pre[i]) begin
            stepa(pre[i], prx[i]);
            e = qa.pop_front();
            n_cmp++;
            if (ifa.data !== e.data || ifa.frame_tick !== e.tick) begin
                n_err++;
                $display("FAIL %s idx=%0d: data=%h tick=%b, want data=%h tick=%b",
                         tname, e.idx, ifa.data, ifa.frame_tick, e.data, e.tick);
            end
        end
        for (int r = 0; r < 64; r++) begin
            stepa(pix(16, r), 16'h001F);
            e = qa.pop_front();
            n_cmp++;
            if (ifa.data !== e.data) begin
                n_err++;
                $display("FAIL %s_column idx=%0d: data=%h, want %h", tname, e.idx, ifa.data, e.data);
            end
        end

        // Fall 8 frames: bars drop to 14, peaks held at 16 but markers disabled
        tname = "clamp_nopeak";
        ifa.level_in = '0;
        npk = 0;
        for (int k = 0; k < 8 * 2 + 128; k++) begin
            int idx;
            if (k < 16) idx = k % 2 == 0 ? 1 : 0;
            else        idx = pix((k - 16) < 64 ? 16 : 48, (k - 16) % 64);
            stepa(idx, mpix_a(idx));
            e = qa.pop_front();
            n_cmp++;
            if (ifa.data === 16'hFFFF) npk++;
            if (ifa.data !== e.data || ifa.frame_tick !== e.tick) begin
                n_err++;
                $display("FAIL %s idx=%0d: data=%h tick=%b, want data=%h tick=%b",
                         tname, e.idx, ifa.data, ifa.frame_tick, e.data, e.tick);
            end
        end
        foreach (post[i]) begin
            stepa(post[i], pox[i]);
            e = qa.pop_front();
            n_cmp++;
            if (ifa.data !== e.data) begin
                n_err++;
                $display("FAIL %s idx=%0d: data=%h, want %h", tname, e.idx, ifa.data, e.data);
            end
        end
        n_cmp++;
        if (npk != 0) begin
            n_err++;
            $display("FAIL %s_count: peak pixels=%0d, want 0", tname, npk);
        end

        tname = "clamp_peak_on";
        ifa.peak_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            stepa(pix(i == 0 ? 16 : 48, 0), 16'hFFFF);
            e = qa.pop_front();
            n_cmp++;
            if (ifa.data !== e.data) begin
                n_err++;
                $display("FAIL %s idx=%0d: data=%h, want %h", tname, e.idx, ifa.data, e.data);
            end
        end
    endtask

    task automatic test_freeze();
        exp_t e;
        int   seq[4] = '{1, 0, pix(20, 16), pix(20, 15)};
        int   rel[4] = '{1, 0, pix(20, 8), pix(20, 7)};
        logic [15:0] relx[4] = '{16'h0000, 16'h0000, 16'h001F, 16'h0000};
        int   nticks;
        do_reset();
        tname = "freeze_setup";
        ifa.peak_en  = 1'b1;
        ifa.level_in = {15'd0, 5'd12};
        for (int i = 0; i < 2; i++) begin
            stepa(seq[i], mpix_a(seq[i]));
            e = qa.pop_front();
            n_cmp++;
            if (ifa.data !== e.data || ifa.frame_tick !== e.tick) begin
                n_err++;
                $display("FAIL %s idx=%0d: data=%h tick=%b, want data=%h tick=%b",
                         tname, e.idx, ifa.data, ifa.frame_tick, e.data, e.tick);
            end
        end

        tname = "freeze";
        ifa.freeze = 1'b1;
        nticks = 0;
        for (int k = 0; k < 10; k++) begin
            ifa.level_in = 20'($urandom());
            foreach (seq[i]) begin
                stepa(seq[i], (i == 2) ? 16'h001F : (i == 3) ? 16'h0000 : mpix_a(seq[i]));
                e = qa.pop_front();
                n_cmp++;
                if (ifa.frame_tick === 1'b1) nticks++;
                if (ifa.data !== e.data || ifa.frame_tick !== e.tick) begin
                    n_err++;
                    $display("FAIL %s k=%0d idx=%0d: data=%h tick=%b, want data=%h tick=%b",
                             tname, k, e.idx, ifa.data, ifa.frame_tick, e.data, e.tick);
                end
            end
        end
        n_cmp++;
        if (nticks != 10) begin
            n_err++;
            $display("FAIL freeze_ticks: ticks=%0d, want 10", nticks);
        end

        tname = "freeze_release";
        ifa.freeze   = 1'b0;
        ifa.level_in = {15'd0, 5'd14};
        foreach (rel[i]) begin
            stepa(rel[i], relx[i]);
            e = qa.pop_front();
            n_cmp++;
            if (ifa.data !== e.data || ifa.frame_tick !== (i == 1)) begin
                n_err++;
                $display("FAIL %s idx=%0d: data=%h tick=%b, want data=%h tick=%b",
                         tname, e.idx, ifa.data, ifa.frame_tick, e.data, (i == 1));
            end
        end
    endtask

    task automatic test_gradient();
        exp_t e;
        int   gc[19] = '{ 1, 0, 20, 20, 20, 26, 27, 25, 28, 64, 73, 74, 76, 15, 20, 20, 20, 20, 63};
        int   gr[19] = '{ 0, 0, 60, 30,  5, 60, 60, 60, 60, 60,  5, 60, 60, 60, 42, 41, 21, 20, 60};
        logic [15:0] gx[19] = '{16'h0000, 16'h0000, 16'h07E0, 16'hFFE0, 16'hF800,
                                16'h0000, 16'h0000, 16'h07E0, 16'h07E0, 16'h07E0,
                                16'hF800, 16'h0000, 16'h0000, 16'h0000, 16'h07E0,
                                16'hFFE0, 16'hFFE0, 16'hF800, 16'h0000};
        do_reset();
        tname = "gradient";
        ifb.peak_en  = 1'b1;
        ifb.level_in = {5'd16, 5'd16, 5'd16, 5'd16, 5'd16};
        foreach (gc[i]) begin
            stepb((i < 2) ? gc[i] : pix(gc[i], gr[i]), gx[i]);
            e = qb.pop_front();
            n_cmp++;
            if (ifb.data !== e.data || ifb.frame_tick !== e.tick) begin
                n_err++;
                $display("FAIL %s idx=%0d: data=%h tick=%b, want data=%h tick=%b",
                         tname, e.idx, ifb.data, ifb.frame_tick, e.data, e.tick);
            end
        end
    endtask

    initial begin
        ifa.level_in = '0; ifa.index = '0; ifa.freeze = 1'b0; ifa.peak_en = 1'b1;
        ifb.level_in = '0; ifb.index = '0; ifb.freeze = 1'b0; ifb.peak_en = 1'b1;
        model_clear();
        repeat (2) @(negedge clk);
        test_reset();
        test_full_bar();
        test_decay();
        test_clamp();
        test_freeze();
        test_gradient();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
